// File: rtl/uart_transmit.sv
// uart_transmit: 8-bit UART transmitter with a one-entry holding register.
// It supports optional odd/even parity and 1 or 2 stop bits.
module uart_transmit #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 100,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] data_byte_in,
  input  logic       trigger_in,
  output logic       ready_out,
  output logic       busy_out,
  output logic       tx_wire_out
);
  localparam int PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int BW = $clog2(PERIOD) + 1;
  localparam logic [BW-1:0] LAST = BW'(PERIOD - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_transmit: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_transmit: STOP_BITS must be 1 or 2");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift_reg, hold_reg;
  logic hold_full, par_bit, load, bit_end, tx_n;
  assign ready_out = !hold_full;
  always_comb begin
    bit_end = baud_cnt == LAST;
    state_n = state;
    bit_n = bit_cnt;
    load = 1'b0;
    case (state)
      IDLE: if (hold_full) begin
        load = 1'b1;
        state_n = START;
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n = '0;
      end
      DATA: if (bit_end) begin
        bit_n = bit_cnt + 3'd1;
        state_n = bit_cnt == 3'd7 ? (PARITY != 0 ? PAR : STOP) : DATA;
      end
      PAR: if (bit_end) begin
        state_n = STOP;
        bit_n = '0;
      end
      STOP: if (bit_end) begin
        bit_n = bit_cnt == LAST_STOP ? 3'd0 : bit_cnt + 3'd1;
        load = bit_cnt == LAST_STOP && hold_full;
        state_n = bit_cnt != LAST_STOP ? STOP : hold_full ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
    baud_n = (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
    // Line value is computed for the state being entered so the output stays registered.
    tx_n = state_n == START ? 1'b0 :
           state_n == DATA  ? shift_reg[bit_n] :
           state_n == PAR   ? par_bit : 1'b1;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift_reg <= '0;
      hold_reg <= '0;
      hold_full <= 1'b0;
      par_bit <= 1'b0;
      tx_wire_out <= 1'b1;
      busy_out <= 1'b0;
    end else begin
      state <= state_n;
      baud_cnt <= baud_n;
      bit_cnt <= bit_n;
      tx_wire_out <= tx_n;
      busy_out <= state_n != IDLE;
      if (load) begin
        shift_reg <= hold_reg;
        par_bit <= PARITY == 2 ? ^hold_reg : ~^hold_reg;
      end
      if (trigger_in && !hold_full) hold_reg <= data_byte_in;
      hold_full <= load ? 1'b0 : (trigger_in && !hold_full) ? 1'b1 : hold_full;
    end
  end
endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: three transmitters (8N1, 8E2, 8O1) checked every cycle against a frame-level model.
// A line decoder on the 8N1 output checks every byte against the accepted-byte queue.
module tb_uart_transmit;
  localparam int P = 10;
  localparam int N = 3;
  logic clk_in = 1'b0, clk_run = 1'b0, rst_n_in = 1'b1, trigger_in = 1'b0;
  logic [7:0] data_byte_in = '0;
  logic [N-1:0] ready, busy, tx;
  int checks = 0, errors = 0;

  uart_transmit #(.INPUT_CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_byte_in(data_byte_in), .trigger_in(trigger_in),
    .ready_out(ready[0]), .busy_out(busy[0]), .tx_wire_out(tx[0]));
  uart_transmit #(.INPUT_CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_byte_in(data_byte_in), .trigger_in(trigger_in),
    .ready_out(ready[1]), .busy_out(busy[1]), .tx_wire_out(tx[1]));
  uart_transmit #(.INPUT_CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_byte_in(data_byte_in), .trigger_in(trigger_in),
    .ready_out(ready[2]), .busy_out(busy[2]), .tx_wire_out(tx[2]));

  always #5 if (clk_run) clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int par_of(input int i);
    return i == 1 ? 2 : i == 2 ? 1 : 0;
  endfunction
  function automatic int stp_of(input int i);
    return i == 1 ? 2 : 1;
  endfunction

  // Frame-level model: a list of line bits per frame and a cycle position inside it.
  logic m_full [N];
  logic [7:0] m_hold [N];
  logic m_act [N];
  int m_pos [N];
  int m_len [N];
  logic m_bits [N][12];
  logic [7:0] rx_q[$];

  task automatic build(input int i, input logic [7:0] b);
    int k;
    k = 0;
    m_bits[i][k] = 1'b0; k = k + 1;
    for (int j = 0; j < 8; j++) begin m_bits[i][k] = b[j]; k = k + 1; end
    if (par_of(i) != 0) begin m_bits[i][k] = par_of(i) == 2 ? ^b : ~^b; k = k + 1; end
    for (int s = 0; s < stp_of(i); s++) begin m_bits[i][k] = 1'b1; k = k + 1; end
    m_len[i] = k;
  endtask

  initial forever begin
    @(posedge clk_in or negedge rst_n_in);
    for (int i = 0; i < N; i++) begin
      if (!rst_n_in) begin
        m_full[i] = 1'b0; m_act[i] = 1'b0; m_pos[i] = 0; m_len[i] = 1;
        if (i == 0) rx_q.delete();
      end else begin
        logic take, fin;
        take = trigger_in && !m_full[i];
        fin = m_act[i] && m_pos[i] == m_len[i] * P - 1;
        if (m_full[i] && (!m_act[i] || fin)) begin
          build(i, m_hold[i]); m_act[i] = 1'b1; m_pos[i] = 0; m_full[i] = 1'b0;
        end else if (fin) m_act[i] = 1'b0;
        else if (m_act[i]) m_pos[i] = m_pos[i] + 1;
        if (take) begin
          m_full[i] = 1'b1; m_hold[i] = data_byte_in;
          if (i == 0) rx_q.push_back(data_byte_in);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (rst_n_in)
      for (int i = 0; i < N; i++) begin
        check($sformatf("ready%0d", i), ready[i], !m_full[i]);
        check($sformatf("busy%0d", i), busy[i], m_act[i]);
        check($sformatf("tx%0d", i), tx[i], m_act[i] ? m_bits[i][m_pos[i] / P] : 1'b1);
      end
  end

  // Line decoder on the 8N1 output, sampling mid-bit.
  int cyc = 0, d_c = 0, d_start = 0, d_start_prev = 0, rx_count = 0;
  logic d_on = 1'b0;
  logic [7:0] d_byte = '0, last_rx = '0, prev_rx = '0;
  initial forever begin
    @(negedge clk_in or negedge rst_n_in);
    if (!rst_n_in) d_on = 1'b0;
    else begin
      cyc++;
      if (!d_on) begin
        if (!tx[0]) begin d_on = 1'b1; d_c = 0; d_start_prev = d_start; d_start = cyc; end
      end else begin
        d_c++;
        if (d_c == 5) check("rx_start_bit", tx[0], 1'b0);
        if (d_c % 10 == 5 && d_c >= 15 && d_c <= 85) d_byte[(d_c - 15) / 10] = tx[0];
        if (d_c == 95) begin
          d_on = 1'b0;
          check("rx_stop_bit", tx[0], 1'b1);
          prev_rx = last_rx; last_rx = d_byte; rx_count++;
          check("rx_pending", rx_q.size() > 0, 1'b1);
          if (rx_q.size() > 0) check("rx_byte", d_byte, rx_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (!ready[0] && t < 1000) begin @(posedge clk_in); #1; t++; end
    check("ready_wait", ready[0], 1'b1);
    data_byte_in = b; trigger_in = 1'b1;
    @(posedge clk_in); #1;
    trigger_in = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy != '0 || ready != '1) && t < 3000) begin @(posedge clk_in); #1; t++; end
    check("idle_wait", {busy, ready}, {3'b000, 3'b111});
  endtask

  initial begin
    int r0;
    #1 rst_n_in = 1'b0;
    #2;
    check("rst_noclk_tx", tx, 3'b111);
    check("rst_noclk_ready", ready, 3'b111);
    check("rst_noclk_busy", busy, 3'b000);
    clk_run = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_tx", tx, 3'b111);
    check("rst_ready", ready, 3'b111);
    check("rst_busy", busy, 3'b000);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    // single byte 0x55 on 8N1
    send(8'h55);
    @(negedge clk_in);
    check("lat_tx_hold", tx[0], 1'b1);
    check("lat_ready", ready[0], 1'b0);
    @(negedge clk_in);
    check("lat_tx_start", tx[0], 1'b0);
    repeat (5) @(negedge clk_in);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bit55_%0d", k), tx[0], k % 2);
      if (k < 9) repeat (10) @(negedge clk_in);
    end
    repeat (4) @(negedge clk_in);
    check("busy_c100", busy[0], 1'b1);
    @(negedge clk_in);
    check("busy_c101", busy[0], 1'b0);
    check("rx_55", last_rx, 8'h55);
    wait_idle();
    // back-to-back
    send(8'hA5);
    check("b2b_ready1", ready[0], 1'b0);
    send(8'h3C);
    check("b2b_ready2", ready[0], 1'b0);
    wait_idle();
    check("b2b_first", prev_rx, 8'hA5);
    check("b2b_second", last_rx, 8'h3C);
    check("b2b_gap", d_start - d_start_prev, 100);
    // parity and stop bits with 0x07
    send(8'h07);
    @(negedge clk_in);
    repeat (96) @(negedge clk_in);
    check("even_par", tx[1], 1'b1);
    check("odd_par", tx[2], 1'b0);
    repeat (10) @(negedge clk_in);
    check("even_stop1", tx[1], 1'b1);
    check("odd_stop", tx[2], 1'b1);
    repeat (10) @(negedge clk_in);
    check("even_stop2", tx[1], 1'b1);
    repeat (4) @(negedge clk_in);
    check("e2_busy_c119", busy[1], 1'b1);
    @(negedge clk_in);
    check("e2_busy_c120", busy[1], 1'b0);
    wait_idle();
    // backpressure
    r0 = rx_count;
    send(8'h12);
    send(8'h34);
    check("bp_ready", ready[0], 1'b0);
    data_byte_in = 8'hFF; trigger_in = 1'b1;
    @(posedge clk_in); #1;
    trigger_in = 1'b0;
    wait_idle();
    check("bp_count", rx_count - r0, 2);
    check("bp_first", prev_rx, 8'h12);
    check("bp_held", last_rx, 8'h34);
    // reset mid-frame with the clock stopped
    send(8'h00);
    send(8'h99);
    repeat (30) @(posedge clk_in);
    @(negedge clk_in);
    check("mid_low", tx[0], 1'b0);
    clk_run = 1'b0;
    #2 rst_n_in = 1'b0;
    #1;
    check("async_tx", tx, 3'b111);
    check("async_ready", ready, 3'b111);
    check("async_busy", busy, 3'b000);
    clk_run = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    r0 = rx_count;
    send(8'h81);
    wait_idle();
    check("post_rst_count", rx_count - r0, 1);
    check("post_rst_byte", last_rx, 8'h81);
    // random loopback
    r0 = rx_count;
    for (int n = 0; n < 256; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 40)) @(posedge clk_in);
        #1;
      end
      send(8'($urandom));
    end
    wait_idle();
    check("loop_count", rx_count - r0, 256);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
